// File: rtl/lcd_hd44780_pkg.sv
// Shared constants and types for the HD44780 display-side receiver.
package lcd_hd44780_pkg;

    // Bus interface mode and, in 4-bit mode, which nibble comes next.
    typedef enum logic [1:0] {
        MODE8    = 2'd0,
        MODE4_HI = 2'd1,
        MODE4_LO = 2'd2
    } lcd_mode_e;

    // Command opcodes: a byte matches when (byte & MASK) == BASE.
    localparam logic [7:0] CMD_CLR_MASK   = 8'hFF;
    localparam logic [7:0] CMD_CLR_BASE   = 8'h01;
    localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
    localparam logic [7:0] CMD_HOME_BASE  = 8'h02;
    localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
    localparam logic [7:0] CMD_ENTRY_BASE = 8'h04;
    localparam logic [7:0] CMD_DISP_MASK  = 8'hF8;
    localparam logic [7:0] CMD_DISP_BASE  = 8'h08;
    localparam logic [7:0] CMD_SHIFT_MASK = 8'hF0;
    localparam logic [7:0] CMD_SHIFT_BASE = 8'h10;
    localparam logic [7:0] CMD_FUNC_MASK  = 8'hE0;
    localparam logic [7:0] CMD_FUNC_BASE  = 8'h20;
    localparam logic [7:0] CMD_CGRAM_MASK = 8'hC0;
    localparam logic [7:0] CMD_CGRAM_BASE = 8'h40;
    localparam logic [7:0] CMD_DDRAM_MASK = 8'h80;
    localparam logic [7:0] CMD_DDRAM_BASE = 8'h80;

    // Character written to every cell by clear-display.
    localparam logic [7:0] FILL_CHAR = 8'h20;

    function automatic logic cmd_is(input logic [7:0] b,
                                    input logic [7:0] mask,
                                    input logic [7:0] base);
        return (b & mask) == base;
    endfunction

endpackage

// File: rtl/lcd_hd44780_rx_if.sv
// HD44780 4-bit parallel bus as seen between controller and display.
interface lcd_hd44780_rx_if;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] lcd_d;

    modport master (output lcd_en, lcd_rs, lcd_rw, lcd_d);
    modport slave  (input  lcd_en, lcd_rs, lcd_rw, lcd_d);
endinterface

// File: rtl/lcd_bus_sync.sv
// Brings the asynchronous LCD bus into the clk domain and marks EN falling edges.
module lcd_bus_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [3:0] lcd_d,
    output logic       strobe,
    output logic       rs,
    output logic       rw,
    output logic [3:0] d
);
    // Bit order in the stages: {en, rs, rw, d[3:0]}.
    logic [6:0] meta_r;
    logic [6:0] sync_r;
    logic       en_prev_r;

    // Two-flop synchronizer plus one extra EN stage for edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_r    <= 7'd0;
            sync_r    <= 7'd0;
            en_prev_r <= 1'b0;
        end else begin
            meta_r    <= {lcd_en, lcd_rs, lcd_rw, lcd_d};
            sync_r    <= meta_r;
            en_prev_r <= sync_r[6];
        end
    end

    // RS/RW/D come from the same synchronized stage that shows EN low.
    assign strobe = en_prev_r & ~sync_r[6];
    assign rs     = sync_r[5];
    assign rw     = sync_r[4];
    assign d      = sync_r[3:0];

endmodule

// File: rtl/lcd_hd44780_rx.sv
// HD44780 display-side receiver: nibble reassembly, command decode,
// DDRAM write port, busy-time model and protocol-violation flagging.
module lcd_hd44780_rx
    import lcd_hd44780_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int BUSY_SHORT_CYC = 1850,
    parameter int BUSY_LONG_CYC  = 76000,
    parameter int DDRAM_DEPTH    = 80
) (
    input  logic              clk,
    input  logic              rst_n,
    lcd_hd44780_rx_if.slave   bus,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_rs,
    output logic              mode4,
    output logic              ddram_we,
    output logic [6:0]        ddram_addr,
    output logic [7:0]        ddram_wdata,
    output logic [6:0]        addr_cnt,
    output logic              display_on,
    output logic              cursor_on,
    output logic              blink_on,
    output logic              entry_inc,
    output logic              two_line,
    output logic              busy,
    output logic              viol,
    output logic [7:0]        viol_cnt
);
    // CLK_HZ only documents where the cycle constants come from; it must be positive.
    localparam int BUSY_MAX = (BUSY_LONG_CYC > BUSY_SHORT_CYC) ? BUSY_LONG_CYC : BUSY_SHORT_CYC;
    localparam int BUSY_W   = $clog2(BUSY_MAX + 1) + ((CLK_HZ > 0) ? 0 : 1);
    localparam logic [BUSY_W-1:0] BUSY_SHORT_L = BUSY_W'(BUSY_SHORT_CYC);
    localparam logic [BUSY_W-1:0] BUSY_LONG_L  = BUSY_W'(BUSY_LONG_CYC);
    localparam logic [BUSY_W-1:0] BUSY_ZERO    = {BUSY_W{1'b0}};
    localparam logic [6:0]        FILL_LAST    = 7'(DDRAM_DEPTH - 1);

    logic       strobe_s, sync_rs_s, sync_rw_s;
    logic [3:0] sync_d_s;

    lcd_bus_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .lcd_en (bus.lcd_en),
        .lcd_rs (bus.lcd_rs),
        .lcd_rw (bus.lcd_rw),
        .lcd_d  (bus.lcd_d),
        .strobe (strobe_s),
        .rs     (sync_rs_s),
        .rw     (sync_rw_s),
        .d      (sync_d_s)
    );

    lcd_mode_e         state_r, state_seq_s, state_nxt;
    logic [3:0]        hi_r, hi_nxt;
    logic              hi_rs_r, hi_rs_nxt;
    logic              mode4_r;
    logic              done_s, rs_s, rw_viol_s;
    logic [7:0]        byte_s;

    logic              valid_r, valid_nxt;
    logic [7:0]        data_r, data_nxt;
    logic              brs_r, brs_nxt;
    logic              we_r, we_nxt;
    logic [6:0]        waddr_r, waddr_nxt;
    logic [7:0]        wdata_r, wdata_nxt;
    logic [6:0]        addr_r, addr_nxt;
    logic              disp_r, disp_nxt, curs_r, curs_nxt, blink_r, blink_nxt;
    logic              inc_r, inc_nxt, two_r, two_nxt;
    logic [BUSY_W-1:0] busy_cnt_r, busy_cnt_nxt;
    logic              busy_r;
    logic              fill_act_r, fill_act_nxt;
    logic [6:0]        fill_addr_r, fill_addr_nxt;
    logic              viol_r, viol_nxt;
    logic [7:0]        viol_cnt_r;

    // Bus FSM: turns strobes into completed bytes and tracks the nibble phase.
    always_comb begin
        state_seq_s = state_r;
        hi_nxt      = hi_r;
        hi_rs_nxt   = hi_rs_r;
        done_s      = 1'b0;
        byte_s      = 8'h00;
        rs_s        = 1'b0;
        rw_viol_s   = 1'b0;
        if (strobe_s) begin
            if (sync_rw_s) begin
                rw_viol_s = 1'b1;
            end else begin
                case (state_r)
                    MODE8: begin
                        done_s = 1'b1;
                        byte_s = {sync_d_s, 4'h0};
                        rs_s   = sync_rs_s;
                    end
                    MODE4_HI: begin
                        hi_nxt      = sync_d_s;
                        hi_rs_nxt   = sync_rs_s;
                        state_seq_s = MODE4_LO;
                    end
                    MODE4_LO: begin
                        done_s      = 1'b1;
                        byte_s      = {hi_r, sync_d_s};
                        rs_s        = hi_rs_r;
                        state_seq_s = MODE4_HI;
                    end
                    default: begin
                        state_seq_s = MODE8;
                    end
                endcase
            end
        end else begin
            rw_viol_s = 1'b0;
        end
    end

    // Applies accepted bytes, runs the clear fill and the busy countdown.
    always_comb begin
        state_nxt     = state_seq_s;
        valid_nxt     = 1'b0;
        data_nxt      = data_r;
        brs_nxt       = brs_r;
        we_nxt        = 1'b0;
        waddr_nxt     = waddr_r;
        wdata_nxt     = wdata_r;
        addr_nxt      = addr_r;
        disp_nxt      = disp_r;
        curs_nxt      = curs_r;
        blink_nxt     = blink_r;
        inc_nxt       = inc_r;
        two_nxt       = two_r;
        fill_act_nxt  = fill_act_r;
        fill_addr_nxt = fill_addr_r;
        viol_nxt      = rw_viol_s;
        busy_cnt_nxt  = (busy_cnt_r != BUSY_ZERO) ? busy_cnt_r - BUSY_W'(1) : busy_cnt_r;

        if (fill_act_r) begin
            we_nxt        = 1'b1;
            waddr_nxt     = fill_addr_r;
            wdata_nxt     = FILL_CHAR;
            fill_addr_nxt = fill_addr_r + 7'd1;
            fill_act_nxt  = (fill_addr_r != FILL_LAST);
        end else begin
            fill_addr_nxt = fill_addr_r;
        end

        if (done_s) begin
            if (fill_act_r) begin
                // A byte during the clear fill is the only one that is discarded.
                viol_nxt = 1'b1;
            end else begin
                viol_nxt     = (busy_cnt_r != BUSY_ZERO);
                valid_nxt    = 1'b1;
                data_nxt     = byte_s;
                brs_nxt      = rs_s;
                busy_cnt_nxt = BUSY_SHORT_L;
                if (rs_s) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = addr_r;
                    wdata_nxt = byte_s;
                    addr_nxt  = inc_r ? addr_r + 7'd1 : addr_r - 7'd1;
                end else if (cmd_is(byte_s, CMD_DDRAM_MASK, CMD_DDRAM_BASE)) begin
                    addr_nxt = byte_s[6:0];
                end else if (cmd_is(byte_s, CMD_CGRAM_MASK, CMD_CGRAM_BASE)) begin
                    addr_nxt = addr_r;
                end else if (cmd_is(byte_s, CMD_FUNC_MASK, CMD_FUNC_BASE)) begin
                    two_nxt   = byte_s[3];
                    state_nxt = byte_s[4] ? MODE8 : MODE4_HI;
                end else if (cmd_is(byte_s, CMD_SHIFT_MASK, CMD_SHIFT_BASE)) begin
                    addr_nxt = addr_r;
                end else if (cmd_is(byte_s, CMD_DISP_MASK, CMD_DISP_BASE)) begin
                    disp_nxt  = byte_s[2];
                    curs_nxt  = byte_s[1];
                    blink_nxt = byte_s[0];
                end else if (cmd_is(byte_s, CMD_ENTRY_MASK, CMD_ENTRY_BASE)) begin
                    inc_nxt = byte_s[1];
                end else if (cmd_is(byte_s, CMD_HOME_MASK, CMD_HOME_BASE)) begin
                    addr_nxt     = 7'd0;
                    busy_cnt_nxt = BUSY_LONG_L;
                end else if (cmd_is(byte_s, CMD_CLR_MASK, CMD_CLR_BASE)) begin
                    addr_nxt      = 7'd0;
                    inc_nxt       = 1'b1;
                    fill_act_nxt  = 1'b1;
                    fill_addr_nxt = 7'd0;
                    busy_cnt_nxt  = BUSY_LONG_L;
                end else begin
                    addr_nxt = addr_r;
                end
            end
        end else begin
            valid_nxt = 1'b0;
        end
    end

    // Bus FSM state register and nibble latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= MODE8;
            hi_r    <= 4'h0;
            hi_rs_r <= 1'b0;
            mode4_r <= 1'b0;
        end else begin
            state_r <= state_nxt;
            hi_r    <= hi_nxt;
            hi_rs_r <= hi_rs_nxt;
            mode4_r <= (state_nxt != MODE8);
        end
    end

    // Datapath, display state, busy and violation registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_r     <= 1'b0;
            data_r      <= 8'h00;
            brs_r       <= 1'b0;
            we_r        <= 1'b0;
            waddr_r     <= 7'd0;
            wdata_r     <= 8'h00;
            addr_r      <= 7'd0;
            disp_r      <= 1'b0;
            curs_r      <= 1'b0;
            blink_r     <= 1'b0;
            inc_r       <= 1'b1;
            two_r       <= 1'b0;
            busy_cnt_r  <= BUSY_ZERO;
            busy_r      <= 1'b0;
            fill_act_r  <= 1'b0;
            fill_addr_r <= 7'd0;
            viol_r      <= 1'b0;
            viol_cnt_r  <= 8'h00;
        end else begin
            valid_r     <= valid_nxt;
            data_r      <= data_nxt;
            brs_r       <= brs_nxt;
            we_r        <= we_nxt;
            waddr_r     <= waddr_nxt;
            wdata_r     <= wdata_nxt;
            addr_r      <= addr_nxt;
            disp_r      <= disp_nxt;
            curs_r      <= curs_nxt;
            blink_r     <= blink_nxt;
            inc_r       <= inc_nxt;
            two_r       <= two_nxt;
            busy_cnt_r  <= busy_cnt_nxt;
            busy_r      <= (busy_cnt_nxt != BUSY_ZERO);
            fill_act_r  <= fill_act_nxt;
            fill_addr_r <= fill_addr_nxt;
            viol_r      <= viol_nxt;
            if (viol_nxt && (viol_cnt_r != 8'hFF)) begin
                viol_cnt_r <= viol_cnt_r + 8'd1;
            end else begin
                viol_cnt_r <= viol_cnt_r;
            end
        end
    end

    assign byte_valid  = valid_r;
    assign byte_data   = data_r;
    assign byte_rs     = brs_r;
    assign mode4       = mode4_r;
    assign ddram_we    = we_r;
    assign ddram_addr  = waddr_r;
    assign ddram_wdata = wdata_r;
    assign addr_cnt    = addr_r;
    assign display_on  = disp_r;
    assign cursor_on   = curs_r;
    assign blink_on    = blink_r;
    assign entry_inc   = inc_r;
    assign two_line    = two_r;
    assign busy        = busy_r;
    assign viol        = viol_r;
    assign viol_cnt    = viol_cnt_r;

endmodule

// File: tb/tb_lcd_hd44780_rx.sv
// Scoreboard bench for lcd_hd44780_rx: stimulus pushes expected bytes and
// DDRAM writes into queues, a negedge monitor pops and compares them.
module tb_lcd_hd44780_rx;
    localparam int SHORT = 50;
    localparam int LONG  = 300;
    localparam int DEPTH = 80;
    localparam int GAP   = SHORT + 20;
    localparam int LGAP  = LONG + 20;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lcd_hd44780_rx_if bus ();

    logic       byte_valid, byte_rs, mode4, ddram_we;
    logic [7:0] byte_data, ddram_wdata, viol_cnt;
    logic [6:0] ddram_addr, addr_cnt;
    logic       display_on, cursor_on, blink_on, entry_inc, two_line, busy, viol;

    lcd_hd44780_rx #(
        .CLK_HZ(50000000), .BUSY_SHORT_CYC(SHORT), .BUSY_LONG_CYC(LONG), .DDRAM_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_rs(byte_rs),
        .mode4(mode4), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
        .ddram_wdata(ddram_wdata), .addr_cnt(addr_cnt), .display_on(display_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .entry_inc(entry_inc),
        .two_line(two_line), .busy(busy), .viol(viol), .viol_cnt(viol_cnt)
    );

    logic [8:0]  exp_byte_q[$];   // {rs, byte}
    logic [14:0] exp_wr_q[$];     // {addr, data}
    int n_pass = 0;
    int n_total = 0;
    int viol_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (byte_valid) begin
                chk("byte_pending", int'(exp_byte_q.size() > 0), 1);
                if (exp_byte_q.size() > 0) chk("byte", {byte_rs, byte_data}, exp_byte_q.pop_front());
            end
            if (ddram_we) begin
                chk("wr_pending", int'(exp_wr_q.size() > 0), 1);
                if (exp_wr_q.size() > 0) chk("ddram_wr", {ddram_addr, ddram_wdata}, exp_wr_q.pop_front());
            end
            if (viol) viol_seen++;
        end
    end

    task automatic nib(input logic rs, input logic rw, input logic [3:0] d);
        bus.lcd_rs = rs;
        bus.lcd_rw = rw;
        bus.lcd_d  = d;
        repeat (2) @(negedge clk);
        bus.lcd_en = 1'b1;
        repeat (4) @(negedge clk);
        bus.lcd_en = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_byte(input logic rs, input logic [7:0] b, input int gap);
        nib(rs, 1'b0, b[7:4]);
        nib(rs, 1'b0, b[3:0]);
        repeat (gap) @(negedge clk);
    endtask

    task automatic push_fill();
        for (int a = 0; a < DEPTH; a++) exp_wr_q.push_back({7'(a), 8'h20});
    endtask

    initial begin
        string msg;
        logic [7:0] ch;
        logic [3:0] init_nib [4];
        msg = "THE GAME  ";
        init_nib = '{4'h3, 4'h3, 4'h3, 4'h2};
        bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.lcd_d = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_flags", {display_on, cursor_on, blink_on, two_line, mode4, busy,
                            byte_valid, ddram_we, viol}, 0);
        chk("reset_entry_inc", entry_inc, 1);
        chk("reset_addr_cnt", addr_cnt, 0);
        chk("reset_viol_cnt", viol_cnt, 0);

        // Init sequence in 8-bit mode.
        for (int i = 0; i < 4; i++) begin
            exp_byte_q.push_back({1'b0, init_nib[i], 4'h0});
            nib(1'b0, 1'b0, init_nib[i]);
            if (i == 2) chk("mode4_still_8bit", mode4, 0);
            repeat (GAP) @(negedge clk);
        end
        chk("mode4_after_init", mode4, 1);

        // Configuration in 4-bit mode.
        exp_byte_q.push_back(9'h028); send_byte(1'b0, 8'h28, GAP);
        chk("two_line", two_line, 1);
        exp_byte_q.push_back(9'h008); send_byte(1'b0, 8'h08, GAP);
        exp_byte_q.push_back(9'h001); push_fill(); send_byte(1'b0, 8'h01, LGAP);
        exp_byte_q.push_back(9'h006); send_byte(1'b0, 8'h06, GAP);
        exp_byte_q.push_back(9'h00C); send_byte(1'b0, 8'h0C, GAP);
        chk("entry_inc", entry_inc, 1);
        chk("disp_cur_blink", {display_on, cursor_on, blink_on}, 3'b100);
        chk("addr_after_clear", addr_cnt, 0);

        // Text write.
        for (int i = 0; i < 10; i++) begin
            ch = msg[i];
            exp_byte_q.push_back({1'b1, ch});
            exp_wr_q.push_back({7'(i), ch});
            send_byte(1'b1, ch, GAP);
        end
        chk("addr_after_text", addr_cnt, 7'h0A);
        chk("viol_cnt_clean", viol_cnt, 0);

        // Addressing and wrap in both directions.
        exp_byte_q.push_back(9'h0FF); send_byte(1'b0, 8'hFF, GAP);
        chk("addr_set_7f", addr_cnt, 7'h7F);
        exp_byte_q.push_back({1'b1, 8'h58}); exp_wr_q.push_back({7'h7F, 8'h58});
        send_byte(1'b1, 8'h58, GAP);
        chk("addr_wrap_up", addr_cnt, 7'h00);
        exp_byte_q.push_back(9'h004); send_byte(1'b0, 8'h04, GAP);
        chk("entry_dec", entry_inc, 0);
        exp_byte_q.push_back({1'b1, 8'h59}); exp_wr_q.push_back({7'h00, 8'h59});
        send_byte(1'b1, 8'h59, GAP);
        chk("addr_wrap_down", addr_cnt, 7'h7F);
        chk("viol_cnt_still0", viol_cnt, 0);

        // A data byte whose completing strobe lands inside the clear fill is dropped.
        exp_byte_q.push_back(9'h001); push_fill(); send_byte(1'b0, 8'h01, 0);
        send_byte(1'b1, 8'h5A, LGAP);
        chk("drop_viol_cnt", viol_cnt, 1);
        chk("drop_viol_pulses", viol_seen, 1);
        chk("drop_addr_cnt", addr_cnt, 0);
        chk("clear_entry_inc", entry_inc, 1);

        // Read strobe is ignored and flagged; the nibble phase is untouched.
        nib(1'b0, 1'b1, 4'h3);
        repeat (10) @(negedge clk);
        chk("rw_viol_cnt", viol_cnt, 2);
        chk("rw_mode4", mode4, 1);
        exp_byte_q.push_back(9'h00C); send_byte(1'b0, 8'h0C, GAP);
        chk("rw_viol_pulses", viol_seen, 2);

        // Reset with a byte's busy time running and a high nibble pending.
        exp_byte_q.push_back(9'h006); send_byte(1'b0, 8'h06, 0);
        nib(1'b0, 1'b0, 4'h2);
        chk("busy_before_reset", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mode4", mode4, 0);
        chk("rst_busy", busy, 0);
        chk("rst_viol_cnt", viol_cnt, 0);
        chk("rst_valid", byte_valid, 0);
        chk("rst_entry_addr", {entry_inc, addr_cnt}, 8'h80);
        rst_n = 1'b1;
        @(negedge clk);
        exp_byte_q.push_back(9'h030); nib(1'b0, 1'b0, 4'h3);
        repeat (GAP) @(negedge clk);
        chk("post_reset_mode4", mode4, 0);

        repeat (20) @(negedge clk);
        chk("byte_q_empty", exp_byte_q.size(), 0);
        chk("wr_q_empty", exp_wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
